// File: rtl/modinv_scheduler.sv
// modinv_scheduler: round-robin arbiter sharing one modular-inverse engine among N_REQ requesters.
//   clk, reset       : clock, synchronous active-high reset
//   req              : per-requester request, held until its done pulse
//   op_a, op_b       : packed operands (requester i at [WIDTH*i +: WIDTH])
//   gnt, done        : one-hot owner, one-cycle completion pulse to owner
//   result, err      : inverse of the last job (0 on error) and its error flag
//   eng_a, eng_b     : registered operands to the engine
//   eng_start        : engine restart, high for one cycle per job and during reset
//   eng_d            : engine output, nonzero means ready
module modinv_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic [WIDTH-1:0]       eng_a,
    output logic [WIDTH-1:0]       eng_b,
    output logic                   eng_start,
    input  logic [WIDTH-1:0]       eng_d
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    state_t            state_q;
    logic [IW-1:0]     ptr_q, pick;
    logic [CW-1:0]     cnt_q;
    logic [N_REQ-1:0]  pick_oh;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic              found, bad;
    // Walk from farthest to nearest after the last owner so the nearest requester wins.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[IW'((int'(ptr_q) + k) % N_REQ)]) begin
                pick  = IW'((int'(ptr_q) + k) % N_REQ);
                found = 1'b1;
            end
        end
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IW'(k)) begin
                a_sel = op_a[k*WIDTH +: WIDTH];
                b_sel = op_b[k*WIDTH +: WIDTH];
            end
        end
        pick_oh = N_REQ'(1) << pick;
        bad     = (a_sel == '0) || ($signed(b_sel) < 2);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(N_REQ - 1);
            cnt_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            result    <= '0;
            err       <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            eng_start <= 1'b1;
        end else begin
            done      <= '0;
            eng_start <= 1'b0;
            case (state_q)
                IDLE: if (found) begin
                    gnt   <= pick_oh;
                    ptr_q <= pick;
                    eng_a <= a_sel;
                    eng_b <= b_sel;
                    cnt_q <= '0;
                    if (bad) begin
                        state_q <= DONE;
                        result  <= '0;
                        err     <= 1'b1;
                        done    <= pick_oh;
                    end else begin
                        state_q   <= START;
                        eng_start <= 1'b1;
                    end
                end
                START: state_q <= WAIT;
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A ready engine on the final allowed cycle still counts as success.
                    if (eng_d != '0) begin
                        result  <= eng_d;
                        err     <= 1'b0;
                        done    <= gnt;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        result  <= '0;
                        err     <= 1'b1;
                        done    <= gnt;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modinv_scheduler.sv
// tb_modinv_scheduler: self-checking bench for modinv_scheduler with a behavioural engine and arbitration model.
module tb_modinv_scheduler;
    localparam int N = 4, W = 32, T = 500;
    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] op_a = '0, op_b = '0;
    logic [N-1:0] gnt, done;
    logic [W-1:0] result, eng_a, eng_b, eng_d;
    logic err, eng_start;
    int passed = 0, total = 0;
    int ecnt = 0, lat = 0;
    bit stuck = 1'b0;
    int ra[N], rb[N];

    modinv_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start), .eng_d(eng_d)
    );

    always #5 clk = ~clk;

    function automatic longint modinv(longint a, longint b);
        longint t = 0, nt = 1, r = b, nr, q, tmp;
        if (b < 2) return 0;
        nr = a % b;
        if (nr < 0) nr += b;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (r != 1) return 0;
        if (t < 0) t += b;
        return t;
    endfunction

    // Engine: answers lat cycles after its restart is released, or never when stuck.
    always @(posedge clk) ecnt <= eng_start ? 0 : ecnt + 1;
    assign eng_d = (!stuck && !eng_start && ecnt >= lat) ? W'(modinv(longint'(eng_a), longint'(eng_b))) : '0;

    task automatic set_ops(input int i, input int a, input int b);
        op_a[i*W +: W] = W'(a);
        op_b[i*W +: W] = W'(b);
        ra[i] = a;
        rb[i] = b;
    endtask

    task automatic wait_job(input int bound, output int gcyc, output int dcyc, output logic [N-1:0] g,
                            output logic [N-1:0] d, output int starts, output bit unstable);
        gcyc = 0; dcyc = 0; g = '0; d = '0; starts = 0; unstable = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (eng_start) starts++;
            if (gnt != '0) begin
                if (gcyc == 0) begin gcyc = c; g = gnt; end
                else if (gnt !== g) unstable = 1'b1;
            end
            if (done != '0) begin dcyc = c; d = done; break; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        total++; if (gnt !== '0) $display("FAIL reset_gnt got %b want 0000", gnt); else passed++;
        total++; if (done !== '0) $display("FAIL reset_done got %b want 0000", done); else passed++;
        total++; if (result !== '0 || err !== 1'b0) $display("FAIL reset_result got %0d/%b want 0/0", result, err); else passed++;
        total++; if (eng_a !== '0 || eng_b !== '0) $display("FAIL reset_eng_ops got %0d/%0d want 0/0", eng_a, eng_b); else passed++;
        total++; if (eng_start !== 1'b1) $display("FAIL reset_eng_start got %b want 1", eng_start); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int gc, dc, st; logic [N-1:0] g, d; bit un;
        set_ops(0, 2, 94849); lat = 0; stuck = 1'b0;
        req = 4'b0001;
        wait_job(50, gc, dc, g, d, st, un);
        total++; if (dc == 0) $display("FAIL single_timeout no done seen"); else passed++;
        total++; if (g !== 4'b0001 || gc != 1) $display("FAIL single_gnt got %b@%0d want 0001@1", g, gc); else passed++;
        total++; if (st != 1) $display("FAIL single_starts got %0d want 1", st); else passed++;
        total++; if (dc - gc + 1 != 3) $display("FAIL single_latency got %0d want 3", dc - gc + 1); else passed++;
        total++; if (d !== 4'b0001 || result !== 47425 || err !== 1'b0)
            $display("FAIL single_result got %b/%0d/%b want 0001/47425/0", d, result, err); else passed++;
        total++; if (eng_a !== 2 || eng_b !== 94849) $display("FAIL single_eng_ops got %0d/%0d want 2/94849", eng_a, eng_b); else passed++;
        req = '0;
        @(negedge clk);
        total++; if (done !== '0 || gnt !== '0 || result !== 47425)
            $display("FAIL single_after got done=%b gnt=%b res=%0d want 0000/0000/47425", done, gnt, result); else passed++;
    endtask

    task automatic test_two();
        int gc, dc, st; logic [N-1:0] g, d; bit un;
        do_reset();
        set_ops(1, 3, 7); set_ops(3, 3, 7); lat = 1;
        req = 4'b1010;
        wait_job(50, gc, dc, g, d, st, un);
        total++; if (g !== 4'b0010 || d !== 4'b0010 || result !== 5 || err !== 1'b0)
            $display("FAIL two_first got g=%b d=%b res=%0d err=%b want 0010/0010/5/0", g, d, result, err); else passed++;
        req[1] = 1'b0;
        wait_job(50, gc, dc, g, d, st, un);
        total++; if (g !== 4'b1000 || d !== 4'b1000 || result !== 5 || gc != 2 || un)
            $display("FAIL two_second got g=%b d=%b res=%0d gcyc=%0d unstable=%b want 1000/1000/5/2/0", g, d, result, gc, un); else passed++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reject();
        int gc, dc, st; logic [N-1:0] g, d; bit un;
        for (int j = 0; j < 2; j++) begin
            if (j == 0) set_ops(2, 5, 1); else set_ops(2, 0, 7);
            lat = 0;
            req = 4'b0100;
            wait_job(50, gc, dc, g, d, st, un);
            total++; if (d !== 4'b0100 || dc - gc + 1 != 1 || st != 0 || err !== 1'b1 || result !== '0)
                $display("FAIL reject%0d got d=%b lat=%0d starts=%0d err=%b res=%0d want 0100/1/0/1/0",
                         j, d, dc - gc + 1, st, err, result); else passed++;
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int gc, dc, st; logic [N-1:0] g, d; bit un;
        int lats[3] = '{-1, T, T - 1};
        for (int j = 0; j < 3; j++) begin
            stuck = (lats[j] < 0);
            lat = stuck ? 0 : lats[j];
            set_ops(0, 3, 7);
            req = 4'b0001;
            wait_job(T + 100, gc, dc, g, d, st, un);
            total++;
            if (j < 2 && (dc == 0 || dc - gc + 1 != T + 2 || err !== 1'b1 || result !== '0))
                $display("FAIL timeout%0d got lat=%0d err=%b res=%0d want %0d/1/0", j, dc - gc + 1, err, result, T + 2);
            else if (j == 2 && (dc == 0 || dc - gc + 1 != T + 2 || err !== 1'b0 || result !== 5))
                $display("FAIL timeout_edge got lat=%0d err=%b res=%0d want %0d/0/5", dc - gc + 1, err, result, T + 2);
            else passed++;
            req = '0;
            @(negedge clk);
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int gc, dc, st; logic [N-1:0] g, d; bit un;
        set_ops(1, 3, 7); lat = 50;
        req = 4'b0010;
        repeat (5) @(negedge clk);
        total++; if (gnt !== 4'b0010) $display("FAIL mid_gnt got %b want 0010", gnt); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (gnt !== '0 || done !== '0 || result !== '0 || err !== 1'b0 || eng_start !== 1'b1)
            $display("FAIL mid_reset got gnt=%b done=%b res=%0d err=%b start=%b want 0000/0000/0/0/1",
                     gnt, done, result, err, eng_start); else passed++;
        reset = 1'b0;
        set_ops(3, 2, 94849); lat = 0;
        req = 4'b1000;
        wait_job(50, gc, dc, g, d, st, un);
        total++; if (g !== 4'b1000 || d !== 4'b1000 || result !== 47425 || gc != 1)
            $display("FAIL mid_after got g=%b d=%b res=%0d gcyc=%0d want 1000/1000/47425/1", g, d, result, gc); else passed++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int gc, dc, st, ptr, own, exp_lat, exp_res, bad_cnt; logic [N-1:0] g, d; bit un, exp_err;
        do_reset();
        ptr = N - 1;
        bad_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < N; i++)
                set_ops(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5000)),
                           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 100000)));
            lat = $urandom_range(0, 6);
            req = N'($urandom_range(1, 15));
            own = -1;
            for (int k = N; k >= 1; k--) if (req[(ptr + k) % N]) own = (ptr + k) % N;
            ptr = own;
            if (ra[own] == 0 || rb[own] < 2) begin exp_err = 1; exp_res = 0; exp_lat = 1; end
            else begin
                exp_res = int'(modinv(ra[own], rb[own]));
                exp_err = (exp_res == 0);
                exp_lat = exp_err ? T + 2 : lat + 3;
            end
            wait_job(T + 100, gc, dc, g, d, st, un);
            if (g !== N'(1 << own) || d !== N'(1 << own) || dc == 0 || dc - gc + 1 != exp_lat ||
                err !== exp_err || result !== W'(exp_res) || un) bad_cnt++;
            if (g !== N'(1 << own) || d !== N'(1 << own) || dc == 0 || dc - gc + 1 != exp_lat ||
                err !== exp_err || result !== W'(exp_res) || un)
                $display("FAIL random%0d got g=%b d=%b lat=%0d err=%b res=%0d want owner=%0d lat=%0d err=%b res=%0d",
                         j, g, d, dc - gc + 1, err, result, own, exp_lat, exp_err, exp_res);
            req = '0;
            @(negedge clk);
        end
        total++; if (bad_cnt != 0) $display("FAIL random_jobs got %0d bad jobs want 0", bad_cnt); else passed++;
    endtask

    task automatic test_rotate();
        int gc, dc, st, a; logic [N-1:0] g, d; bit un;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a = $urandom_range(1, 7918);
            set_ops(i, a, 7919);
        end
        req = '1;
        for (int j = 0; j < 8; j++) begin
            lat = $urandom_range(0, 4);
            wait_job(100, gc, dc, g, d, st, un);
            total++;
            if (g !== N'(1 << (j % N)) || d !== g || gc != (j == 0 ? 1 : 2) ||
                result !== W'(modinv(ra[j % N], 7919)) || dc - gc + 1 != lat + 3)
                $display("FAIL rotate%0d got g=%b d=%b gcyc=%0d res=%0d lat=%0d want %b/%b/%0d/%0d/%0d", j, g, d, gc, result,
                         dc - gc + 1, N'(1 << (j % N)), N'(1 << (j % N)), (j == 0 ? 1 : 2), modinv(ra[j % N], 7919), lat + 3);
            else passed++;
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_reject();
        test_timeout();
        test_reset_mid();
        test_random();
        test_rotate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
